cs_overwrite_q: RTL and testbench

- Successor to the decode-stage control-store overwrite logic.
- Applies ModRM, operand-size and segment overrides to the raw control-store word and registers the result into a parametrised DEPTH-entry queue.
- Queue uses a valid/ready handshake toward the register-read stage.
- Adds REP replay: a REP-prefixed word is re-issued from the queue head until the execute side signals completion.

---
 rtl/cs_ovr_pkg.sv | 25 ++
 rtl/cs_ovr_apply.sv | 62 ++++++
 rtl/cs_overwrite_q.sv | 118 +++++++++++
 tb/tb_cs_overwrite_q.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cs_ovr_pkg.sv
// cs_ovr_pkg: control-store field layout, override constant and head FSM states for cs_overwrite_q.
package cs_ovr_pkg;
  localparam int ISDBL_LSB = 0;
  localparam int SIZE_LSB  = 1;
  localparam int SIZE_W    = 2;
  localparam int IMMSZ_LSB = 3;
  localparam int ISMOD_LSB = 5;
  localparam int OPMOD_LSB = 6;
  localparam int S3MOD_LSB = 8;
  localparam int R1MOD_LSB = 9;
  localparam int M1RW_LSB  = 10;
  localparam int M2RW_LSB  = 12;
  localparam int RW_W      = 2;
  localparam int R1_LSB    = 14;
  localparam int R2_LSB    = 17;
  localparam int S1_LSB    = 20;
  localparam int S3_LSB    = 23;
  localparam int REG_W     = 3;
  localparam int DEST1_LSB = 26;
  localparam int OP1_LSB   = 39;
  localparam int DEST2_LSB = 52;
  localparam int OP2_LSB   = 65;
  localparam logic [12:0] MUX_OVR = 13'h0002;
  typedef enum logic [1:0] {ST_EMPTY, ST_ISSUE, ST_REPLAY} hq_state_e;
endpackage

// File: rtl/cs_ovr_apply.sv
// cs_ovr_apply: combinational ModRM / operand-size / segment overrides on a raw control-store word.
module cs_ovr_apply
  import cs_ovr_pkg::*;
#(
  parameter int CS_W  = 227,
  parameter int SEG_N = 6,
  parameter int MUX_W = 13
) (
  input  logic [CS_W-1:0]  cs_in,
  input  logic [7:0]       b2,
  input  logic [7:0]       b3,
  input  logic             is_size,
  input  logic             is_seg,
  input  logic [SEG_N-1:0] seg_sel,
  output logic [CS_W-1:0]  cs_out,
  output logic             any_ovr
);
  logic [7:0] w_m;
  logic w_mod11, w_is_mod, w_sz, w_op0, w_op1, w_s3, w_r1, w_d1, w_d2, w_seg;
  logic [REG_W-1:0] w_seg_idx;
  assign w_m      = cs_in[ISDBL_LSB] ? b3 : b2;
  assign w_mod11  = &w_m[7:6];
  assign w_is_mod = cs_in[ISMOD_LSB];
  assign w_sz     = is_size & (cs_in[SIZE_LSB +: SIZE_W] == 2'b10);
  assign w_op0    = w_is_mod & w_mod11 & cs_in[OPMOD_LSB];
  assign w_op1    = w_is_mod & w_mod11 & cs_in[OPMOD_LSB+1];
  assign w_s3     = w_is_mod & w_mod11 & cs_in[S3MOD_LSB];
  assign w_r1     = w_is_mod & w_mod11 & cs_in[R1MOD_LSB];
  assign w_d1     = cs_in[DEST1_LSB+8] & cs_in[OPMOD_LSB] & w_mod11;
  assign w_d2     = cs_in[DEST2_LSB+8] & cs_in[OPMOD_LSB+1] & w_mod11;
  assign w_seg    = w_is_mod & is_seg;
  assign any_ovr  = |{w_sz, w_op0, w_op1, w_s3, w_r1, w_d1, w_d2, w_seg};
  // seg_sel is one-hot; the highest set bit wins if it is not
  always_comb begin
    w_seg_idx = '0;
    for (int i = 0; i < SEG_N; i++)
      if (seg_sel[i]) w_seg_idx = REG_W'(i);
  end
  always_comb begin
    cs_out = cs_in;
    if (w_sz) begin
      cs_out[SIZE_LSB +: SIZE_W]  = 2'b01;
      cs_out[IMMSZ_LSB +: SIZE_W] = 2'b01;
    end
    if (w_op0) begin
      cs_out[M1RW_LSB +: RW_W] = 2'b00;
      cs_out[R2_LSB +: REG_W]  = w_m[2:0];
    end
    if (w_op1) cs_out[M2RW_LSB +: RW_W] = 2'b00;
    if (w_s3) cs_out[S3_LSB +: REG_W] = w_m[5:3];
    if (w_r1) cs_out[R1_LSB +: REG_W] = w_m[5:3];
    if (w_d1) begin
      cs_out[DEST1_LSB +: MUX_W] = MUX_W'(MUX_OVR);
      cs_out[OP1_LSB +: MUX_W]   = MUX_W'(MUX_OVR);
    end
    if (w_d2) begin
      cs_out[DEST2_LSB +: MUX_W] = MUX_W'(MUX_OVR);
      cs_out[OP2_LSB +: MUX_W]   = MUX_W'(MUX_OVR);
    end
    if (w_seg) cs_out[S1_LSB +: REG_W] = w_seg_idx;
  end
endmodule

// File: rtl/cs_overwrite_q.sv
// cs_overwrite_q: overridden control words queued toward register-read, with REP replay at the head.
// Optional override counter port ovr_cnt under CS_OVERWRITE_Q_PERF_EN.
module cs_overwrite_q
  import cs_ovr_pkg::*;
#(
  parameter int CS_W   = 227,
  parameter int DEPTH  = 4,
  parameter int SEG_N  = 6,
  parameter int MUX_W  = 13,
  parameter int REPC_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CS_W-1:0]   cs_in,
  input  logic [7:0]        b2,
  input  logic [7:0]        b3,
  input  logic              is_rep,
  input  logic              is_size,
  input  logic              is_seg,
  input  logic [SEG_N-1:0]  seg_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CS_W-1:0]   cs_out,
  input  logic              rep_done,
  output logic [REPC_W-1:0] rep_iter
`ifdef CS_OVERWRITE_Q_PERF_EN
  ,
  output logic [15:0]       ovr_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [CS_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_rep;
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic r_full;
  hq_state_e r_state, w_state_nxt;
  logic [REPC_W-1:0] r_rep_iter, w_rep_iter_nxt;
  logic [CS_W-1:0] w_word;
  logic w_any_ovr, w_push, w_hs, w_head_rep, w_pop;
  cs_ovr_apply #(.CS_W(CS_W), .SEG_N(SEG_N), .MUX_W(MUX_W)) u_apply (
    .cs_in(cs_in), .b2(b2), .b3(b3), .is_size(is_size), .is_seg(is_seg),
    .seg_sel(seg_sel), .cs_out(w_word), .any_ovr(w_any_ovr)
  );
  assign in_ready   = !r_full;
  assign out_valid  = r_state != ST_EMPTY;
  assign cs_out     = out_valid ? r_mem[r_rp] : '0;
  assign rep_iter   = r_rep_iter;
  assign w_push     = in_valid & !r_full & !flush;
  assign w_hs       = out_valid & out_ready;
  assign w_head_rep = r_rep[r_rp];
  // a REP head leaves the queue only when execute reports completion
  assign w_pop      = w_hs & (!w_head_rep | rep_done);
  assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);
  always_comb begin
    w_state_nxt    = r_state;
    w_rep_iter_nxt = r_rep_iter;
    case (r_state)
      ST_EMPTY: w_state_nxt = (w_cnt_nxt != '0) ? ST_ISSUE : ST_EMPTY;
      ST_ISSUE:
        if (w_hs & w_head_rep & !rep_done) begin
          w_state_nxt    = ST_REPLAY;
          w_rep_iter_nxt = REPC_W'(1);
        end else w_state_nxt = (w_cnt_nxt != '0) ? ST_ISSUE : ST_EMPTY;
      ST_REPLAY:
        if (w_pop) begin
          w_state_nxt    = (w_cnt_nxt != '0) ? ST_ISSUE : ST_EMPTY;
          w_rep_iter_nxt = '0;
        end else if (w_hs) w_rep_iter_nxt = (&r_rep_iter) ? r_rep_iter : r_rep_iter + REPC_W'(1);
      default: w_state_nxt = ST_EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_state    <= ST_EMPTY;
      r_rep_iter <= '0;
    end else if (flush) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_state    <= ST_EMPTY;
      r_rep_iter <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_cnt      <= w_cnt_nxt;
      r_full     <= w_cnt_nxt == CW'(DEPTH);
      r_state    <= w_state_nxt;
      r_rep_iter <= w_rep_iter_nxt;
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= w_word;
      r_rep[r_wp] <= is_rep;
    end
  end
`ifdef CS_OVERWRITE_Q_PERF_EN
  logic [15:0] r_ovr_cnt;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_ovr_cnt <= '0;
    else if (w_push & w_any_ovr) r_ovr_cnt <= r_ovr_cnt + 16'd1;
  end
  assign ovr_cnt = r_ovr_cnt;
`else
  logic w_unused;
  assign w_unused = w_any_ovr;
`endif
endmodule

// File: tb/tb_cs_overwrite_q.sv
// tb_cs_overwrite_q: directed checks of overrides, queue ordering/backpressure, REP replay, reset and flush.
module tb_cs_overwrite_q;
  import cs_ovr_pkg::*;
  localparam int CS_W = 227;
  logic clk = 1'b0, clr = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0, rep_done = 1'b0;
  logic is_rep = 1'b0, is_size = 1'b0, is_seg = 1'b0, in_ready, out_valid;
  logic [CS_W-1:0] cs_in = '0, cs_out;
  logic [7:0] b2 = '0, b3 = '0, rep_iter;
  logic [5:0] seg_sel = '0;
  int n_tests = 0, n_fail = 0;
`ifdef CS_OVERWRITE_Q_PERF_EN
  logic [15:0] ovr_cnt;
`endif
  cs_overwrite_q dut (
    .clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .cs_in(cs_in), .b2(b2), .b3(b3), .is_rep(is_rep), .is_size(is_size), .is_seg(is_seg),
    .seg_sel(seg_sel), .out_valid(out_valid), .out_ready(out_ready), .cs_out(cs_out),
    .rep_done(rep_done), .rep_iter(rep_iter)
`ifdef CS_OVERWRITE_Q_PERF_EN
    , .ovr_cnt(ovr_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [CS_W-1:0] w, input logic [7:0] b2v, input logic sz,
                      input logic sg, input logic [5:0] ss, input logic rp);
    cs_in = w; b2 = b2v; is_size = sz; is_seg = sg; seg_sel = ss; is_rep = rp;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic pop1();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask
  logic [CS_W-1:0] wa, ea, wb, eb, wc, ec, wr, wn;
  logic [CS_W-1:0] wq [4];
  initial begin
    wa = '0; wa[ISMOD_LSB] = 1'b1; wa[R1MOD_LSB] = 1'b1; wa[OPMOD_LSB +: 2] = 2'b01;
    wa[R1_LSB +: 3] = 3'd7; wa[R2_LSB +: 3] = 3'd7; wa[M1RW_LSB +: 2] = 2'b11; wa[M2RW_LSB +: 2] = 2'b11;
    wa[DEST1_LSB +: 13] = 13'h100; wa[OP1_LSB +: 13] = 13'h1ff; wa[200 +: 16] = 16'hbeef;
    ea = wa; ea[R1_LSB +: 3] = 3'd0; ea[R2_LSB +: 3] = 3'd5; ea[M1RW_LSB +: 2] = 2'b00;
    ea[DEST1_LSB +: 13] = 13'h0002; ea[OP1_LSB +: 13] = 13'h0002;
    wb = '0; wb[SIZE_LSB +: 2] = 2'b10; wb[IMMSZ_LSB +: 2] = 2'b11; wb[200 +: 16] = 16'h1234;
    eb = wb; eb[SIZE_LSB +: 2] = 2'b01; eb[IMMSZ_LSB +: 2] = 2'b01;
    wc = '0; wc[ISMOD_LSB] = 1'b1; wc[S1_LSB +: 3] = 3'd7; wc[200 +: 16] = 16'h5a5a;
    ec = wc; ec[S1_LSB +: 3] = 3'd3;
    wr = '0; wr[210 +: 16] = 16'hcafe;
    wn = '0; wn[210 +: 16] = 16'hf00d;
    for (int i = 0; i < 4; i++) begin wq[i] = '0; wq[i][100 +: 8] = 8'(i + 1); end
    step(); step();
    chk("rst_out_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
    chk("rst_rep_iter", 256'(rep_iter), 256'(8'd0));
    chk("rst_cs_out", 256'(cs_out), 256'(0));
    clr = 1'b1;
    step();
    // ModRM overrides, b2=C5
    push(wa, 8'hc5, 1'b0, 1'b0, 6'b0, 1'b0);
    chk("a_valid", 256'(out_valid), 256'(1'b1));
    chk("a_r1", 256'(cs_out[R1_LSB +: 3]), 256'(3'd0));
    chk("a_r2", 256'(cs_out[R2_LSB +: 3]), 256'(3'd5));
    chk("a_m1rw", 256'(cs_out[M1RW_LSB +: 2]), 256'(2'b00));
    chk("a_m2rw", 256'(cs_out[M2RW_LSB +: 2]), 256'(2'b11));
    chk("a_word", 256'(cs_out), 256'(ea));
    pop1();
    chk("a_drained", 256'(out_valid), 256'(1'b0));
    push(wb, 8'h00, 1'b1, 1'b0, 6'b0, 1'b0);
    chk("b_size_ovr", 256'(cs_out), 256'(eb));
    pop1();
    push(wb, 8'h00, 1'b0, 1'b0, 6'b0, 1'b0);
    chk("b_size_keep", 256'(cs_out), 256'(wb));
    pop1();
    push(wc, 8'h00, 1'b0, 1'b1, 6'b001000, 1'b0);
    chk("c_seg_ovr", 256'(cs_out), 256'(ec));
    pop1();
    push(wc, 8'h00, 1'b0, 1'b0, 6'b001000, 1'b0);
    chk("c_seg_keep", 256'(cs_out), 256'(wc));
    pop1();
    // fill to DEPTH, then drain in order
    for (int i = 0; i < 4; i++) begin
      push(wq[i], 8'h00, 1'b0, 1'b0, 6'b0, 1'b0);
      chk("fill_in_ready", 256'(in_ready), 256'(i < 3));
    end
    push(wr, 8'h00, 1'b0, 1'b0, 6'b0, 1'b0);
    chk("full_in_ready", 256'(in_ready), 256'(1'b0));
    chk("full_head", 256'(cs_out), 256'(wq[0]));
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      chk("drain_word", 256'(cs_out), 256'(wq[i]));
      chk("drain_in_ready", 256'(in_ready), 256'(1'b1));
    end
    step();
    out_ready = 1'b0;
    chk("drain_empty", 256'(out_valid), 256'(1'b0));
    chk("drain_cs_zero", 256'(cs_out), 256'(0));
    // REP replay
    push(wr, 8'h00, 1'b0, 1'b0, 6'b0, 1'b1);
    push(wn, 8'h00, 1'b0, 1'b0, 6'b0, 1'b0);
    chk("rep_head", 256'(cs_out), 256'(wr));
    chk("rep_iter0", 256'(rep_iter), 256'(8'd0));
    out_ready = 1'b1;
    rep_done = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("rep_iter", 256'(rep_iter), 256'(8'(k)));
      chk("rep_word", 256'(cs_out), 256'(wr));
      chk("rep_valid", 256'(out_valid), 256'(1'b1));
    end
    rep_done = 1'b1;
    step();
    out_ready = 1'b0;
    rep_done = 1'b0;
    chk("rep_clear", 256'(rep_iter), 256'(8'd0));
    chk("rep_next", 256'(cs_out), 256'(wn));
    pop1();
    chk("rep_empty", 256'(out_valid), 256'(1'b0));
    // async reset mid-replay
    push(wr, 8'h00, 1'b0, 1'b0, 6'b0, 1'b1);
    push(wn, 8'h00, 1'b0, 1'b0, 6'b0, 1'b0);
    pop1();
    chk("clr_pre_iter", 256'(rep_iter), 256'(8'd1));
    clr = 1'b0;
    #1;
    chk("clr_out_valid", 256'(out_valid), 256'(1'b0));
    chk("clr_rep_iter", 256'(rep_iter), 256'(8'd0));
    chk("clr_in_ready", 256'(in_ready), 256'(1'b1));
    step();
    clr = 1'b1;
    step();
    // flush mid-replay, concurrent enqueue dropped
    push(wr, 8'h00, 1'b0, 1'b0, 6'b0, 1'b1);
    push(wn, 8'h00, 1'b0, 1'b0, 6'b0, 1'b0);
    pop1();
    chk("fl_pre_iter", 256'(rep_iter), 256'(8'd1));
    flush = 1'b1;
    push(wn, 8'h00, 1'b0, 1'b0, 6'b0, 1'b0);
    flush = 1'b0;
    chk("fl_out_valid", 256'(out_valid), 256'(1'b0));
    chk("fl_rep_iter", 256'(rep_iter), 256'(8'd0));
    chk("fl_in_ready", 256'(in_ready), 256'(1'b1));
    step();
    chk("fl_dropped", 256'(out_valid), 256'(1'b0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
